// File: rtl/macc_scheduler_if.sv
// macc_scheduler_if: request/grant and RAM address bundle between
// the two channel controllers, the scheduler and the MACC datapath.
interface macc_scheduler_if #(
  parameter int AddrWidth = 4
);
  logic [1:0]           Req_i;
  logic [1:0]           Ack_o;
  logic [AddrWidth-1:0] DataAddr0_i;
  logic [AddrWidth-1:0] DataAddr1_i;
  logic [AddrWidth-1:0] CoeffAddr0_i;
  logic [AddrWidth-1:0] CoeffAddr1_i;
  logic [AddrWidth-1:0] DataAddr_o;
  logic [AddrWidth-1:0] CoeffAddr_o;
  logic                 Chan_o;
  logic                 StartAcc_o;
  logic                 DataValid_o;
  logic                 ValidChan_o;
  logic                 Busy_o;

  modport master (
    output Req_i, DataAddr0_i, DataAddr1_i,
    output CoeffAddr0_i, CoeffAddr1_i,
    input  Ack_o, DataAddr_o, CoeffAddr_o, Chan_o,
    input  StartAcc_o, DataValid_o, ValidChan_o, Busy_o
  );

  modport slave (
    input  Req_i, DataAddr0_i, DataAddr1_i,
    input  CoeffAddr0_i, CoeffAddr1_i,
    output Ack_o, DataAddr_o, CoeffAddr_o, Chan_o,
    output StartAcc_o, DataValid_o, ValidChan_o, Busy_o
  );
endinterface

// File: rtl/macc_scheduler.sv
// macc_scheduler: two-channel job scheduler for one shared MACC datapath.
// Define MACC_SCHED_FIXED_PRIO_EN for fixed ch0 priority (default: round-robin).
module macc_scheduler #(
  parameter int FilterLength   = 16,
  parameter int InterpolationK = 2,
  parameter int AddrWidth      = 4,
  parameter int MaccLatency    = 2
) (
  input  logic            Clk_i,
  input  logic            Rstn_i,
  macc_scheduler_if.slave bus
);
  localparam int CW = AddrWidth + 1;
  localparam logic [CW-1:0] FlCmp = CW'(FilterLength);
  localparam logic [CW-1:0] KStep = CW'(InterpolationK);

  typedef enum logic {IDLE, WORK} state_e;

  state_e               state_q, state_d;
  logic [1:0]           ack_q, ack_d;
  logic [AddrWidth-1:0] data_q, data_d;
  logic [AddrWidth-1:0] coeff_q, coeff_d;
  logic                 chan_q, chan_d;
  logic                 start_q, start_d;
  logic                 rdy_q, rdy_d;
  logic                 rdy_ch_q, rdy_ch_d;

  logic [MaccLatency-1:0] st_dl_q, st_dl_d;
  logic [MaccLatency-1:0] rd_dl_q, rd_dl_d;
  logic [MaccLatency-1:0] rc_dl_q, rc_dl_d;

  logic                 gnt;
  logic [AddrWidth-1:0] sel_data, sel_coeff;
  logic [CW-1:0]        coeff_nxt;
  logic                 last_tap, job_ok;

`ifdef MACC_SCHED_FIXED_PRIO_EN
  // Fixed priority: channel 1 only wins when it requests alone.
  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      (bus.Req_i == 2'b10): gnt = 1'b1;
      default:              gnt = 1'b0;
    endcase
  end
`else
  logic last_q, last_d;

  // Round-robin: a tie goes to the channel that did not win last.
  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      (bus.Req_i == 2'b10): gnt = 1'b1;
      (bus.Req_i == 2'b11): gnt = ~last_q;
      default:              gnt = 1'b0;
    endcase
  end

  // Remember the winner of every grant taken in Idle.
  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && |bus.Req_i) last_d = gnt;
  end

  // Pointer resets to 1 so channel 0 wins the first tie.
  always_ff @(posedge Clk_i or negedge Rstn_i) begin
    if (!Rstn_i) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`endif

  // Grant, address walk and raw start/ready strobes.
  always_comb begin
    sel_data  = gnt ? bus.DataAddr1_i : bus.DataAddr0_i;
    sel_coeff = gnt ? bus.CoeffAddr1_i : bus.CoeffAddr0_i;
    coeff_nxt = {1'b0, coeff_q} + KStep;
    last_tap  = coeff_nxt >= FlCmp;
    job_ok    = {1'b0, sel_coeff} < FlCmp;
    state_d   = state_q;
    ack_d     = 2'b00;
    data_d    = data_q;
    coeff_d   = coeff_q;
    chan_d    = chan_q;
    start_d   = 1'b0;
    rdy_d     = 1'b0;
    rdy_ch_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.Req_i) begin
          ack_d   = gnt ? 2'b10 : 2'b01;
          data_d  = sel_data;
          coeff_d = sel_coeff;
          chan_d  = gnt;
          if (job_ok) begin
            start_d = 1'b1;
            state_d = WORK;
          end
        end
      end
      WORK: begin
        if (last_tap) begin
          rdy_d    = 1'b1;
          rdy_ch_d = chan_q;
          state_d  = IDLE;
        end else begin
          data_d  = data_q - AddrWidth'(1);
          coeff_d = coeff_nxt[AddrWidth-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes ride independent shift lines to line up with the MACC.
  always_comb begin
    st_dl_d    = '0;
    rd_dl_d    = '0;
    rc_dl_d    = '0;
    st_dl_d[0] = start_q;
    rd_dl_d[0] = rdy_q;
    rc_dl_d[0] = rdy_ch_q;
    for (int i = 1; i < MaccLatency; i++) begin
      st_dl_d[i] = st_dl_q[i-1];
      rd_dl_d[i] = rd_dl_q[i-1];
      rc_dl_d[i] = rc_dl_q[i-1];
    end
  end

  // State and pipeline registers; reset aborts any job in flight.
  always_ff @(posedge Clk_i or negedge Rstn_i) begin
    if (!Rstn_i) begin
      state_q  <= IDLE;
      ack_q    <= 2'b00;
      data_q   <= '0;
      coeff_q  <= '0;
      chan_q   <= 1'b0;
      start_q  <= 1'b0;
      rdy_q    <= 1'b0;
      rdy_ch_q <= 1'b0;
      st_dl_q  <= '0;
      rd_dl_q  <= '0;
      rc_dl_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      coeff_q  <= coeff_d;
      chan_q   <= chan_d;
      start_q  <= start_d;
      rdy_q    <= rdy_d;
      rdy_ch_q <= rdy_ch_d;
      st_dl_q  <= st_dl_d;
      rd_dl_q  <= rd_dl_d;
      rc_dl_q  <= rc_dl_d;
    end
  end

  assign bus.Ack_o       = ack_q;
  assign bus.DataAddr_o  = data_q;
  assign bus.CoeffAddr_o = coeff_q;
  assign bus.Chan_o      = chan_q;
  assign bus.Busy_o      = (state_q == WORK);
  assign bus.StartAcc_o  = st_dl_q[MaccLatency-1];
  assign bus.DataValid_o = rd_dl_q[MaccLatency-1];
  assign bus.ValidChan_o = rc_dl_q[MaccLatency-1];
endmodule
